instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the RV32 core, directly upstream of the control unit and decode. It owns the fetch PC, issues in-order word requests to instruction memory over a valid/ready channel, and buffers returned instructions in a small FIFO. It presents them to decode with a valid/ready handshake. It consumes the control unit's `pc_src` together with the sign-extended immediate, redirects on taken BEQ/JAL, and squashes wrong-path fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 4, instruction buffer entries; also the cap on buffered plus outstanding requests (power of 2, ≥2)

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address of request, bits [1:0] always 0
- `imem_rsp_valid`  in  1  response data valid (in order, one per accepted request)
- `imem_rsp_data`  in  32  fetched instruction word
- `instr_valid`  out  1  FIFO head valid
- `instr_ready`  in  1  decode consumes head
- `instr`  out  32  head instruction; `instr[6:0]` drives the control unit opcode
- `instr_pc`  out  32  PC of head instruction
- `instr_pc_plus4`  out  32  `instr_pc + 4` (JAL link value)
- `pc_src`  in  2  from control unit: 00 sequential, 01 taken branch, 10 JAL, 11 reserved (treated as 00)
- `imm_ext`  in  32  sign-extended immediate of head instruction

## Operation
- State: `fetch_pc` (32), FIFO of {instr, pc} × FIFO_DEPTH, `outstanding` count, `discard` count.
- Request: `imem_req_valid = (fifo_count + outstanding) < FIFO_DEPTH`, from registered state only (no same-cycle pop/response bypass). `imem_req_addr = fetch_pc`. On accept (valid & ready): `fetch_pc += 4` (32-bit wrap), `outstanding++`.
- Response: `outstanding--`. If `discard > 0`: drop data, `discard--`. Otherwise push {data, PC of that request}. The request PC is tracked internally in issue order.
- Consume: pop the head when `instr_valid & instr_ready`.
- Redirect: occurs when `instr_valid & instr_ready & (pc_src == 01 | pc_src == 10)`.
  - `fetch_pc <= (instr_pc + imm_ext) & ~32'h3`.
  - FIFO flushed: all entries behind the head are dropped, and the head itself is consumed.
  - `discard <=` outstanding count after this cycle's accept/response updates. This includes a request accepted in the same cycle.
  - A response arriving in the redirect cycle belongs to the old path and is dropped. It is not pushed.
- Request stability: while `imem_req_valid & !imem_req_ready`, the address is held. The only exception is the cycle after a redirect, when the address changes to the target.
- Arithmetic: all PC adds are 32-bit modulo. A target with bits [1:0] ≠ 0 is silently aligned down.

## Timing
- Reset (`rst_n` low, asynchronous):
  - `fetch_pc = RESET_PC`; FIFO empty; `outstanding = discard = 0`.
  - `imem_req_valid = 0` and `instr_valid = 0` while in reset. `instr`, `instr_pc`, `instr_pc_plus4` = 0.
- First request: `imem_req_valid` = 1 in the first cycle after `rst_n` rises, with address RESET_PC.
- Latency: request accepted in cycle N, response in N+k (k ≥ 1), `instr_valid` in N+k+1. The FIFO is registered, with no response-to-output pass-through.
- Throughput: with k = 1, `imem_req_ready` = 1 and `instr_ready` = 1, the unit sustains one instruction per cycle.
- Redirect cycle R:
  - `instr_valid` = 0 in R+1.
  - First request to the target is in R+1.
  - Earliest target instruction at the output is R+3 with k = 1.
- FIFO full with no outstanding requests: `imem_req_valid` = 0 until a pop. The request reasserts the cycle after the pop.
- Simultaneous push and pop on a full FIFO cannot occur, because the credit cap prevents it.
- Reset mid-operation: all in-flight state is abandoned immediately. The bench must also reset the memory model.

## Test plan
- Reset with RESET_PC = 32'h100, ideal memory (k = 1), `instr_ready` = 1 → requests to 0x100, 0x104, 0x108… on consecutive cycles; the first `instr_valid` appears 2 cycles after the first accept with `instr_pc` = 0x100 and `instr_pc_plus4` = 0x104; thereafter one instruction per cycle.
- `instr_ready` held 0 → exactly FIFO_DEPTH (4) requests accepted, then `imem_req_valid` = 0. After a single pop, exactly one new request is issued the next cycle.
- BEQ at PC 0x10C with `pc_src` = 01 and `imm_ext` = 32'hFFFF_FFF8 → next fetch address is 0x104. All wrong-path responses (0x110, 0x114…) are dropped, and the next `instr_pc` presented is 0x104.
- JAL with `pc_src` = 10 and `imm_ext` = 0x20 at PC 0x200, with memory latency k = 3 and 2 requests outstanding → both late responses are discarded, and the first presented `instr_pc` is 0x220.
- A redirect in the same cycle as `imem_rsp_valid` and an accepted request → neither that response nor the response to that request ever appears at `instr`.
- `pc_src` = 11, plus `rst_n` pulsed low mid-stream with 3 requests outstanding → `pc_src` = 11 gives sequential fetch (no redirect). After reset release, fetch restarts at RESET_PC with `instr_valid` = 0 until the new responses return.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// RV32 instruction fetch stage. Owns the fetch PC, issues in-order word
// requests to instruction memory, buffers returned words together with their
// PC in a small FIFO, and hands them to decode over a valid/ready handshake.
// A taken BEQ or a JAL consumed at the head redirects the fetch PC, flushes
// the FIFO and discards every response still in flight for the old path.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_rsp_valid/data         in-order response channel (one per request)
//   instr_valid/ready           head-of-FIFO handshake towards decode
//   instr, instr_pc, instr_pc_plus4   head word, its PC and PC+4 (JAL link)
//   pc_src              00/11 sequential, 01 taken branch, 10 JAL
//   imm_ext             sign-extended immediate of the head instruction
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t        fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:0]   fetch_pc;
    // PC of the next response that will be kept. Kept responses are always
    // sequential from the last redirect (or reset), so one counter replaces
    // a per-request PC queue.
    logic [31:0]   rsp_pc;

    logic          accept, pop, redirect, push;
    logic [CW-1:0] outstanding_next;
    logic [CW:0]   credits_used;
    logic [31:0]   target;
    entry_t        head;

    // Credit cap covers buffered plus in-flight words, so a response always
    // has a FIFO slot. Built from registered state only.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = rst_n && (credits_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;

    assign head           = fifo_mem[rd_ptr];
    assign instr_valid    = (fifo_count != '0);
    // Outputs forced to zero when empty so reset presents all-zero values.
    assign instr          = instr_valid ? head.word : '0;
    assign instr_pc       = instr_valid ? head.pc : '0;
    assign instr_pc_plus4 = instr_valid ? head.pc + 32'd4 : '0;

    assign accept   = imem_req_valid & imem_req_ready;
    assign pop      = instr_valid & instr_ready;
    assign redirect = pop & ((pc_src == 2'b01) || (pc_src == 2'b10));
    // A response landing in the redirect cycle is old-path data: never pushed.
    assign push     = imem_rsp_valid & (discard == '0) & ~redirect;

    assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    assign target           = (head.pc + imm_ext) & ~32'h3;

    // PC and in-flight bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                // Everything still in flight after this cycle, including a
                // request accepted right now, belongs to the old path.
                discard  <= outstanding_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (push)   rsp_pc   <= rsp_pc + 32'd4;
                if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
            end
        end
    end

    // FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect) begin
            // Head is consumed by the redirecting pop; the rest is wrong path.
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage: no reset needed, outputs are masked by instr_valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {imem_rsp_data, rsp_pc};
    end

endmodule
